state_write_arbiter: RTL

Sequences every write into the display block-state register file and arbitrates it between two sources: CPU single-block writes and a built-in board-clear sweep. Sits between the CPU bus and the write port (write enable, address, data) of the state register behind the VGA display. Writes are gated to non-active video so the scan-out never reads a half-updated board.

---
 rtl/state_write_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/state_write_arbiter.sv
// state_write_arbiter
//
// Owns the single write port of the display block-state register file and
// arbitrates it between CPU single-block writes and a built-in board-clear
// sweep. Writes can be held off during active video, so the scan-out never
// reads a half-updated board.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   video_valid  high during active video
//   cpu_req      CPU write request, held until cpu_ack
//   cpu_addr     CPU target address, stable while cpu_req
//   cpu_data     CPU write data, stable while cpu_req
//   cpu_ack      one-cycle pulse: the CPU write is on the port this cycle
//   clr_start    start-clear pulse, only looked at while idle
//   clr_busy     high while a clear is in progress
//   clr_done     one-cycle pulse in the cycle after the last clear write
//   state_we     write enable to the state register
//   reg_addr     write address to the state register
//   data_out     write data to the state register
//
// All outputs come straight from flops. The clear counter holds the next
// address to write; the first clear write is issued on the same edge that
// accepts clr_start when writes are allowed.

module state_write_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned NUM_BLOCKS = 300,
    parameter logic [31:0] FILL_DATA  = 32'h0,
    parameter bit          GATE_BLANK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_valid,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_data,
    output logic              cpu_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              state_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       data_out
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {StIdle, StCpuWr, StClr} state_e;

    state_e state_q, state_d;

    logic              state_we_q, state_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]       data_out_q, data_out_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              ok;
    logic              clr_final;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_cnt_next;

    assign ok = !GATE_BLANK || !video_valid;

    // The final clear write is the only one that targets LastAddr, so seeing
    // it on the port means the sweep has finished.
    assign clr_final = state_we_q && (reg_addr_q == LastAddr);

    // A clear entered from idle always starts at address 0.
    assign clr_addr     = (state_q == StClr) ? cnt_q : '0;
    assign clr_cnt_next = (clr_addr == LastAddr) ? '0 : clr_addr + ADDR_W'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            state_we_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            reg_addr_q <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            state_we_q <= state_we_d;
            cpu_ack_q  <= cpu_ack_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            reg_addr_q <= reg_addr_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClr;
                end else if (cpu_req && ok) begin
                    state_d = StCpuWr;
                end
            end
            StCpuWr: state_d = StIdle;
            StClr: begin
                if (clr_final) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the clear counter.
    always_comb begin
        state_we_d = 1'b0;
        cpu_ack_d  = 1'b0;
        clr_done_d = 1'b0;
        clr_busy_d = clr_busy_q;
        reg_addr_d = reg_addr_q;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    clr_busy_d = 1'b1;
                    cnt_d      = '0;
                    if (ok) begin
                        state_we_d = 1'b1;
                        reg_addr_d = clr_addr;
                        data_out_d = FILL_DATA;
                        cnt_d      = clr_cnt_next;
                    end
                end else if (cpu_req && ok) begin
                    state_we_d = 1'b1;
                    cpu_ack_d  = 1'b1;
                    reg_addr_d = cpu_addr;
                    data_out_d = cpu_data;
                end
            end
            // The write was issued on entry; this cycle only drops it.
            // cpu_req is deliberately not looked at here.
            StCpuWr: ;
            StClr: begin
                if (clr_final) begin
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                    cnt_d      = '0;
                end else if (ok) begin
                    state_we_d = 1'b1;
                    reg_addr_d = clr_addr;
                    data_out_d = FILL_DATA;
                    cnt_d      = clr_cnt_next;
                end
            end
            default: ;
        endcase
    end

    assign state_we = state_we_q;
    assign cpu_ack  = cpu_ack_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign reg_addr = reg_addr_q;
    assign data_out = data_out_q;

endmodule
